relay_encode: RTL and testbench

- Upstream stage of the relay link receive path.
- Takes the raw demodulated pulse signal from the analog front end, synchronises it and rejects glitches by pulse width.
- Emits a symbol-aligned, oversampled serial stream: one symbol is SAMPLES_PER_BIT clocks at a constant level, 1 for a captured pulse and 0 for none.
- The stream is consumed by the relay decoder, which locks on the first high sample and majority-votes each 32-sample window.

---
 rtl/relay_pkg.sv | 27 ++
 rtl/relay_pulse_qualifier.sv | 52 +++++
 rtl/relay_encode.sv | 112 +++++++++++
 tb/tb_relay_encode.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared constants, state encoding and helpers for the relay link encoder.
package relay_pkg;

  localparam int SAMPLES_PER_BIT  = 32;
  localparam int MIN_PULSE_READER = 4;
  localparam int MIN_PULSE_TAG    = 8;
  localparam int IDLE_SYMBOLS     = 8;

  localparam int SYM_CNT_W   = $clog2(SAMPLES_PER_BIT);
  localparam int WIDTH_CNT_W = 4;
  localparam int IDLE_CNT_W  = $clog2(IDLE_SYMBOLS + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Minimum synchronised high time for a pulse, chosen by timing side.
  function automatic logic [WIDTH_CNT_W-1:0] min_pulse(input logic reader_timing);
    if (reader_timing) begin
      min_pulse = WIDTH_CNT_W'(MIN_PULSE_READER);
    end else begin
      min_pulse = WIDTH_CNT_W'(MIN_PULSE_TAG);
    end
  endfunction

endpackage

// File: rtl/relay_pulse_qualifier.sv
// Two-flop synchroniser plus pulse-width qualifier: one accept strobe per
// sufficiently long high pulse on the asynchronous data_in line.
module relay_pulse_qualifier
  import relay_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic reader_timing,
  output logic accept
);

  logic                   sync_1;
  logic                   sync_in;
  logic [WIDTH_CNT_W-1:0] width_cnt;

  // Bring data_in into the clk domain through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1  <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync_1  <= data_in;
      sync_in <= sync_1;
    end
  end

  // Count consecutive high cycles seen before the current one; saturate at 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      width_cnt <= '0;
    end else if (!sync_in) begin
      width_cnt <= '0;
    end else if (width_cnt != 4'hF) begin
      width_cnt <= width_cnt + 4'd1;
    end else begin
      width_cnt <= width_cnt;
    end
  end

  // The running count reaches MIN on the cycle width_cnt holds MIN-1 while
  // still high; saturation keeps a long pulse from ever matching again.
  always_comb begin
    accept = 1'b0;
    if (sync_in && (width_cnt == (min_pulse(reader_timing) - 4'd1))) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
  end

endmodule

// File: rtl/relay_encode.sv
// Relay link encoder: turns qualified pulses into a symbol-aligned,
// oversampled serial stream framed by a run of trailing zero symbols.
module relay_encode
  import relay_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic data_in,
  output logic data_out,
  output logic busy,
  output logic overflow
);

  state_t                 state;
  logic                   mode_lat;
  logic [SYM_CNT_W-1:0]   sym_cnt;
  logic                   pending;
  logic [IDLE_CNT_W-1:0]  idle_cnt;
  logic                   accept;
  logic                   reader_timing;
  logic                   boundary;
  logic                   next_sym;

  relay_pulse_qualifier u_qualifier (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .reader_timing (reader_timing),
    .accept        (accept)
  );

  // Live mode sets the pulse threshold while idle; the latched copy holds for a frame.
  always_comb begin
    reader_timing = mode_lat;
    if (state == IDLE) begin
      reader_timing = mode;
    end else begin
      reader_timing = mode_lat;
    end
  end

  // Symbol boundary detection and the value of the symbol that follows it.
  always_comb begin
    boundary = (sym_cnt == SYM_CNT_W'(SAMPLES_PER_BIT - 1));
    next_sym = pending | accept;
  end

  // Frame FSM: data_out doubles as the current symbol register. idle_cnt
  // counts zero symbols already sent; the frame closes once IDLE_SYMBOLS of
  // them have gone out and another zero would follow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode_lat <= 1'b0;
      sym_cnt  <= '0;
      pending  <= 1'b0;
      idle_cnt <= '0;
      data_out <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_out <= 1'b0;
          busy     <= 1'b0;
          if (accept) begin
            mode_lat <= mode;
            data_out <= 1'b1;
            busy     <= 1'b1;
            sym_cnt  <= '0;
            idle_cnt <= '0;
            pending  <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (boundary) begin
            sym_cnt <= '0;
            pending <= 1'b0;
            if (next_sym) begin
              data_out <= 1'b1;
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_CNT_W'(IDLE_SYMBOLS)) begin
              data_out <= 1'b0;
              busy     <= 1'b0;
              idle_cnt <= '0;
              state    <= IDLE;
            end else begin
              data_out <= 1'b0;
              idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
            end
          end else begin
            sym_cnt <= sym_cnt + SYM_CNT_W'(1);
            if (accept) begin
              pending <= 1'b1;
              if (pending) begin
                overflow <= 1'b1;
              end
            end
          end
        end
        default: begin
          state    <= IDLE;
          data_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relay_encode.sv
// Self-checking bench for relay_encode: the driver pushes the expected
// data_out/busy for every cycle it drives, a negedge monitor pops and compares.
module tb_relay_encode;

  localparam int SPB = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mode = 1'b0;
  logic data_in = 1'b0;
  logic data_out;
  logic busy;
  logic overflow;

  relay_encode dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic  d;
    logic  b;
    int    rel;
    string name;
  } exp_t;

  exp_t exp_q[$];

  // Stimulus description for one test (cycles relative to test start).
  int          p_start[4];
  int          p_width[4];
  int          n_pulse;
  int          tog_at;
  logic        tog_val;
  logic [15:0] syms;
  int          nsym;
  int          sym_start;

  // Compare DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_bit($sformatf("%s data_out@%0d", e.name, e.rel), data_out, e.d);
      check_bit($sformatf("%s busy@%0d", e.name, e.rel), busy, e.b);
    end
  end

  task automatic run_test(input string name, input int len, input logic exp_ov);
    logic hi;
    exp_t e;
    for (int rel = 0; rel < len; rel++) begin
      @(posedge clk);
      #1;
      hi = 1'b0;
      for (int i = 0; i < n_pulse; i++) begin
        if (rel >= p_start[i] && rel < p_start[i] + p_width[i]) hi = 1'b1;
      end
      data_in = hi;
      if (rel == tog_at) mode = tog_val;
      e.rel  = rel;
      e.name = name;
      if (nsym > 0 && rel >= sym_start && rel < sym_start + nsym * SPB) begin
        e.d = syms[(rel - sym_start) / SPB];
        e.b = 1'b1;
      end else begin
        e.d = 1'b0;
        e.b = 1'b0;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    #1;
    check_bit({name, " overflow"}, overflow, exp_ov);
  endtask

  task automatic one_pulse(input int width, input int start, input logic [15:0] s, input int n);
    n_pulse    = 1;
    p_start[0] = 0;
    p_width[0] = width;
    tog_at     = -1;
    tog_val    = 1'b0;
    syms       = s;
    nsym       = n;
    sym_start  = start;
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1;
    check_bit("reset data_out", data_out, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset overflow", overflow, 1'b0);
    #11 reset = 1'b1;

    // Reader timing, 10-cycle pulse: one 1 symbol then 8 zero symbols.
    mode = 1'b1;
    one_pulse(10, 6, 16'h0001, 9);
    run_test("t1_reader", 6 + 9 * SPB + 4, 1'b0);

    // Tag timing, 6-cycle pulse is too short.
    mode = 1'b0;
    one_pulse(6, 0, 16'h0000, 0);
    run_test("t2_short", 40, 1'b0);

    // Tag timing, 8-cycle pulse is exactly long enough: rise at cycle 10.
    one_pulse(8, 10, 16'h0001, 9);
    run_test("t2_tag", 10 + 9 * SPB + 4, 1'b0);

    // Reader timing, 6-cycle pulses every 64 cycles; accepts land on
    // boundaries; mode flips to tag timing mid-frame and must be ignored.
    mode = 1'b1;
    one_pulse(6, 6, 16'h0055, 15);
    n_pulse    = 4;
    p_start[1] = 64;  p_width[1] = 6;
    p_start[2] = 128; p_width[2] = 6;
    p_start[3] = 192; p_width[3] = 6;
    tog_at     = 20;
    tog_val    = 1'b0;
    run_test("t3_pattern", 6 + 15 * SPB + 4, 1'b0);

    // Two pulses 12 cycles apart in one window: merged 1 symbol, overflow.
    mode = 1'b1;
    one_pulse(10, 6, 16'h0005, 11);
    n_pulse    = 3;
    p_start[1] = 40; p_width[1] = 6;
    p_start[2] = 52; p_width[2] = 6;
    run_test("t4_overflow", 6 + 11 * SPB + 4, 1'b1);

    // Minimum-width reader pulse; overflow remains sticky.
    one_pulse(4, 6, 16'h0001, 9);
    run_test("t5_minwidth", 6 + 9 * SPB + 4, 1'b1);

    // Start a frame and stop at cycle 15 of its 1 symbol, then reset.
    one_pulse(10, 6, 16'h0001, 9);
    run_test("t6_prereset", 22, 1'b1);
    #1 reset = 1'b0;
    #1;
    check_bit("t6 async data_out", data_out, 1'b0);
    check_bit("t6 async busy", busy, 1'b0);
    check_bit("t6 async overflow", overflow, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    // Fresh aligned frame after reset release.
    one_pulse(10, 6, 16'h0001, 9);
    run_test("t7_fresh", 6 + 9 * SPB + 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
